first_counter_down: RTL
=======================

// Module: first_counter_down
// PURPOSE
//   Loadable WIDTH-bit down-counter (countdown timer) with terminal-count
//   pulse and sticky underflow flag. Counterpart of the up-counter/overflow
//   block: it counts toward zero and flags the wrap below zero.
//   Used for programmable delays and timeouts. One-shot or auto-reload mode.
// PARAMETERS
//   WIDTH        4   counter width in bits (>=2)
// PORTS
//   clk             input   1      rising-edge clock
//   reset           input   1      asynchronous reset, active-low (0 = reset)
//   load            input   1      load load_value, arm counter
//   load_value      input   WIDTH  start/reload value
//   enable          input   1      decrement qualifier (active high)
//   auto_reload     input   1      1 = reload on underflow, 0 = one-shot
//   clear_flag      input   1      clears underflow_out
//   counter_out     output  WIDTH  current count (registered)
//   underflow_out   output  1      sticky underflow flag (registered)
//   tc_pulse        output  1      1-cycle terminal-count pulse (registered)
//   busy_out        output  1      1 while state==RUN
// BEHAVIOUR
//   Reset (reset==0, async, no clk needed): counter_out=0, underflow_out=0,
//     tc_pulse=0, busy_out=0, reload_reg=0, state=IDLE. Release sync to clk.
//   All outputs registered; every update visible 1 clk after sampling edge.
//   No #delays in assignments.
//   States: IDLE (never loaded), RUN (counting), DONE (one-shot expired).
//   load==1 (highest priority, any state): counter_out<=load_value,
//     reload_reg<=load_value, state<=RUN; enable ignored that cycle;
//     tc_pulse<=0.
//   RUN, enable==1, counter_out!=0: counter_out<=counter_out-1.
//   RUN, enable==1, counter_out==0 (underflow event):
//     tc_pulse<=1 (one cycle), underflow_out<=1;
//     auto_reload==1: counter_out<=reload_reg, stay RUN;
//     auto_reload==0: counter_out holds 0, state<=DONE.
//   RUN, enable==0: hold count; tc_pulse<=0.
//   IDLE/DONE: enable ignored, counter_out holds, tc_pulse<=0.
//   Load of 0: RUN with count 0; next enabled cycle is an underflow event.
//   Auto-reload with reload_reg==0: underflow every enabled cycle, tc_pulse
//     stays high for consecutive events.
//   auto_reload sampled at the event cycle only (may change while running).
//   clear_flag: underflow_out<=0; if an underflow event occurs in the same
//     cycle, set wins (underflow_out=1). clear_flag affects nothing else.
//   load and clear_flag same cycle: both take effect.
//   Arithmetic is modulo 2^WIDTH unsigned; counter never decrements below 0
//     (underflow handled as above, no raw wrap to all-ones).
//   Reset asserted mid-count: immediate return to reset values, all state
//     (incl. reload_reg, sticky flag) lost.
// TESTING (WIDTH=4)
//   1 reset=0 with counter mid-run, no clk edge -> all outputs 0 at once;
//     release, enable=1 without load -> counter_out stays 0, busy_out=0.
//   2 load 4'd3, auto_reload=0, enable=1 -> counter 3,2,1,0; next cycle
//     tc_pulse=1 for exactly 1 clk, underflow_out=1, busy_out=0, count 0.
//   3 load 4'd2, auto_reload=1, enable=1 -> 2,1,0,2,1,0,2; tc_pulse on
//     each 0->2 transition; underflow_out stays 1.
//   4 underflow event with clear_flag=1 same cycle -> underflow_out=1;
//     clear_flag=1 next cycle -> underflow_out=0.
//   5 enable toggled 1/0 from load 4'd5 -> count holds on enable=0 cycles;
//     load 4'd9 asserted with enable=1 mid-count -> counter_out=9, no dec.
//   6 load 4'd0, auto_reload=1, enable=1 -> tc_pulse=1 every cycle, count 0.

Source files
------------

// File: rtl/first_counter_down_if.sv
// Control and status bundle for the first_counter_down countdown timer.
// The master drives the control side and the slave (the counter) returns the registered status.
interface first_counter_down_if #(
  parameter int WIDTH = 4
);
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             enable;
  logic             auto_reload;
  logic             clear_flag;
  logic [WIDTH-1:0] counter_out;
  logic             underflow_out;
  logic             tc_pulse;
  logic             busy_out;

  modport master (
    output load, load_value, enable, auto_reload, clear_flag,
    input  counter_out, underflow_out, tc_pulse, busy_out
  );

  modport slave (
    input  load, load_value, enable, auto_reload, clear_flag,
    output counter_out, underflow_out, tc_pulse, busy_out
  );
endinterface

// File: rtl/first_counter_down.sv
// Loadable down-counter with a terminal-count pulse, a sticky underflow flag,
// and a choice of one-shot or auto-reload operation.
//
// state | meaning
// IDLE  | not loaded since reset; enable is ignored
// RUN   | counting down on enabled cycles
// DONE  | one-shot has expired; the count holds at 0
module first_counter_down #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  first_counter_down_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             uflow_q, uflow_d;
  logic             tc_q, tc_d;
  logic             uflow_event;

  // An underflow is the enabled tick that finds the count already at zero.
  // A load in the same cycle takes priority and suppresses it.
  assign uflow_event = (state_q == S_RUN) && bus.enable && !bus.load &&
                       (count_q == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      reload_q <= '0;
      uflow_q  <= 1'b0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      uflow_q  <= uflow_d;
      tc_q     <= tc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.load) begin
      state_d = S_RUN;
    end else if (uflow_event && !bus.auto_reload) begin
      state_d = S_DONE;
    end
  end

  always_comb begin
    count_d  = count_q;
    reload_d = reload_q;
    tc_d     = uflow_event;
    uflow_d  = uflow_q;

    if (bus.load) begin
      count_d  = bus.load_value;
      reload_d = bus.load_value;
    end else if (uflow_event) begin
      if (bus.auto_reload) begin
        count_d = reload_q;
      end
    end else if ((state_q == S_RUN) && bus.enable) begin
      count_d = count_q - 1'b1;
    end

    // A set in the same cycle wins over clear_flag.
    if (uflow_event) begin
      uflow_d = 1'b1;
    end else if (bus.clear_flag) begin
      uflow_d = 1'b0;
    end
  end

  assign bus.counter_out   = count_q;
  assign bus.underflow_out = uflow_q;
  assign bus.tc_pulse      = tc_q;
  assign bus.busy_out      = (state_q == S_RUN);

endmodule
